// File: rtl/dct_transpose_buf.sv
// ---------------------------------------------------------------------------
// dct_transpose_buf
//
// Corner-turn buffer between the row-pass and column-pass of an 8x8 2-D DCT.
// Rows of a block are written in acceptance order (row 0..7, element 0..7),
// and the block is then read out column by column (column 0..7), where
// output j of column c is element c of input row j, unchanged.
//
// Build option:
//   TRANSPOSE_PINGPONG_EN  defined   -> two banks; one fills while the other
//                                       drains, so full-rate streaming runs
//                                       with no bubbles.
//                          undefined -> one bank; the writer stalls while a
//                                       full block drains.
//
// Ports:
//   clk                 single clock, all state on the rising edge
//   rst_n               asynchronous, active-low reset
//   i_in_valid          row presented by the row-pass DCT
//   o_in_ready          current write bank is FREE, a row can be taken
//   i_in0..i_in7        row elements, column index 0..7
//   o_out_valid         a column is presented to the column-pass DCT
//   i_out_ready         downstream accepts the column this cycle
//   o_out0..o_out7      column elements, row index 0..7 (zero when idle)
//   o_out_last          high with column 7 of a block
//
// Bank state table:
//   state     | meaning
//   BANK_FREE | bank may be written; its contents are never shown on outputs
//   BANK_FULL | bank holds a complete block and is being read out by column
// ---------------------------------------------------------------------------
module dct_transpose_buf #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  input  logic [DATA_W-1:0] i_in0,
  input  logic [DATA_W-1:0] i_in1,
  input  logic [DATA_W-1:0] i_in2,
  input  logic [DATA_W-1:0] i_in3,
  input  logic [DATA_W-1:0] i_in4,
  input  logic [DATA_W-1:0] i_in5,
  input  logic [DATA_W-1:0] i_in6,
  input  logic [DATA_W-1:0] i_in7,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [DATA_W-1:0] o_out0,
  output logic [DATA_W-1:0] o_out1,
  output logic [DATA_W-1:0] o_out2,
  output logic [DATA_W-1:0] o_out3,
  output logic [DATA_W-1:0] o_out4,
  output logic [DATA_W-1:0] o_out5,
  output logic [DATA_W-1:0] o_out6,
  output logic [DATA_W-1:0] o_out7,
  output logic              o_out_last
);

`ifdef TRANSPOSE_PINGPONG_EN
  localparam int NB = 2;
`else
  localparam int NB = 1;
`endif

  typedef enum logic {
    BANK_FREE = 1'b0,
    BANK_FULL = 1'b1
  } bank_st_t;

  bank_st_t          r_bank_st [NB];
  logic              r_wr_bank;
  logic              r_rd_bank;
  logic [2:0]        r_wr_row;
  logic [2:0]        r_rd_col;

  // Storage is deliberately not reset: a bank is only ever shown on the
  // outputs after all eight of its rows have been rewritten.
  logic [DATA_W-1:0] r_mem [NB][8][8];

  logic [DATA_W-1:0] w_in  [8];
  logic [DATA_W-1:0] w_col [8];
  logic              w_in_xfer;
  logic              w_out_xfer;

  assign w_in[0] = i_in0;
  assign w_in[1] = i_in1;
  assign w_in[2] = i_in2;
  assign w_in[3] = i_in3;
  assign w_in[4] = i_in4;
  assign w_in[5] = i_in5;
  assign w_in[6] = i_in6;
  assign w_in[7] = i_in7;

  // Both handshakes come straight from bank state flops, so in_ready has no
  // combinational path from out_ready and a bank freed on one edge only
  // becomes writable on the next.
  assign o_in_ready  = (r_bank_st[r_wr_bank] == BANK_FREE);
  assign o_out_valid = (r_bank_st[r_rd_bank] == BANK_FULL);

  assign w_in_xfer  = i_in_valid  && o_in_ready;
  assign w_out_xfer = o_out_valid && i_out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int b = 0; b < NB; b++) begin
        r_bank_st[b] <= BANK_FREE;
      end
      r_wr_bank <= 1'b0;
      r_rd_bank <= 1'b0;
      r_wr_row  <= 3'd0;
      r_rd_col  <= 3'd0;
    end else begin
      // The write and read sides never touch the same bank on one edge:
      // writing needs FREE, reading needs FULL.
      if (w_in_xfer) begin
        r_wr_row <= r_wr_row + 3'd1;
        if (r_wr_row == 3'd7) begin
          r_bank_st[r_wr_bank] <= BANK_FULL;
`ifdef TRANSPOSE_PINGPONG_EN
          r_wr_bank <= ~r_wr_bank;
`else
          r_wr_bank <= 1'b0;
`endif
        end
      end
      if (w_out_xfer) begin
        r_rd_col <= r_rd_col + 3'd1;
        if (r_rd_col == 3'd7) begin
          r_bank_st[r_rd_bank] <= BANK_FREE;
`ifdef TRANSPOSE_PINGPONG_EN
          r_rd_bank <= ~r_rd_bank;
`else
          r_rd_bank <= 1'b0;
`endif
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_in_xfer) begin
      for (int c = 0; c < 8; c++) begin
        r_mem[r_wr_bank][r_wr_row][c] <= w_in[c];
      end
    end
  end

  // Column read is a plain mux of stored flops, so the outputs stay stable
  // for as long as the read pointer does (i.e. while stalled).
  always_comb begin
    for (int j = 0; j < 8; j++) begin
      w_col[j] = '0;
      if (o_out_valid) begin
        w_col[j] = r_mem[r_rd_bank][j][r_rd_col];
      end
    end
  end

  assign o_out0     = w_col[0];
  assign o_out1     = w_col[1];
  assign o_out2     = w_col[2];
  assign o_out3     = w_col[3];
  assign o_out4     = w_col[4];
  assign o_out5     = w_col[5];
  assign o_out6     = w_col[6];
  assign o_out7     = w_col[7];
  assign o_out_last = o_out_valid && (r_rd_col == 3'd7);

endmodule

// File: doc/dct_transpose_buf.md
DCT_TRANSPOSE_BUF -- requirements
Module: dct_transpose_buf

Interface
REQ-001 Parameter: DATA_W, default 16, width of each coefficient.
REQ-002 clk  input  1  single clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  row-pass DCT output row presented.
REQ-005 in_ready  output  1  buffer can accept a row this cycle.
REQ-006 in0..in7  input  DATA_W each  row elements, column index 0..7.
REQ-007 out_valid  output  1  column presented to column-pass DCT.
REQ-008 out_ready  input  1  downstream accepts column this cycle.
REQ-009 out0..out7  output  DATA_W each  column elements, row index 0..7.
REQ-010 out_last  output  1  high with column 7 of a block.

Function
REQ-011 Input transfer occurs on an edge where in_valid && in_ready; output transfer occurs on an edge where out_valid && out_ready.
REQ-012 Input rows of a block are numbered 0..7 by acceptance order; a write row counter wraps 7->0 and marks the written bank FULL on accepting row 7.
REQ-013 For output column c (0..7) of a block, outj equals element c of input row j, bit-exact, no arithmetic or width change.
REQ-014 Each bank holds two states: FREE (writable) and FULL (readable); a bank returns to FREE on the edge accepting its column 7.
REQ-015 Latency: out_valid rises in the cycle immediately after the edge accepting row 7, provided the read side is idle.
REQ-016 Columns are emitted in order 0..7; the read column counter advances only on output transfer and wraps 7->0.
REQ-017 While out_valid && !out_ready, out0..out7, out_last and out_valid hold stable.
REQ-018 out0..out7 and out_last are 0 whenever out_valid is 0.
REQ-019 in_ready = 1 iff the current write bank is FREE; in_ready does not depend combinationally on out_ready.
REQ-020 A bank freed on edge N is writable in cycle N+1; no bypass within one cycle.
REQ-021 in_valid with in_ready low has no effect; inputs are not required to be held.

Reset
REQ-022 On rst_n low, asynchronously: all banks FREE, write/read bank selects 0, row and column counters 0, out_valid 0, out_last 0, in_ready 1 after release.
REQ-023 Reset mid-block discards any partial or undrained block; bank storage contents are not reset and never reach outputs before being rewritten.

Configuration
REQ-024 Macro TRANSPOSE_PINGPONG_EN defined: two banks alternate; one fills while the other drains; continuous 8-rows-in/8-columns-out streaming with out_ready tied 1 sustains one transfer per cycle on each side, no bubbles.
REQ-025 Macro TRANSPOSE_PINGPONG_EN undefined: single bank; in_ready low from the edge accepting row 7 until the edge accepting column 7; one block per 16 cycles minimum.

Verification
REQ-026 Single block, row r element c = r*16+c, out_ready=1 -> column c cycles 1..8 after row 7: outj = j*16+c; out_last only on c=7.
REQ-027 Pingpong, 4 back-to-back blocks (block b adds b*256), out_ready=1 -> in_ready never low, 32 columns contiguous, values correct.
REQ-028 out_ready low for 3 cycles during column 2 -> column 2 data held unchanged; column 3 follows after out_ready returns; no column lost or repeated.
REQ-029 rst_n pulsed low after row 4 accepted, then fresh block -> out_valid 0 throughout reset; only the fresh block's 8 columns emitted.
REQ-030 Macro undefined, continuous in_valid -> in_ready low exactly 8 cycles per block with out_ready=1; columns correct.
REQ-031 Pingpong, out_ready=0 permanently -> exactly 16 rows accepted, then in_ready stays 0; releasing out_ready drains 16 columns in order.
